// File: rtl/spi_byte_engine.sv
// spi_byte_engine: byte-wide mode-0 SPI master with read-ahead dummy transfers.
// Optional slow sclk timing is built only when SPI_SLOW_MODE_EN is defined.
module spi_byte_engine #(
  parameter logic [7:0] SLOW_DIV = 8'd63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       enviar_dato,
  input  logic       recibir_dato,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe,
  output logic       spi_transfer_in_progress,
  input  logic       slow,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  logic [1:0] state;
  logic       prev_wr;
  logic       prev_rd;
  logic       pend_wr;
  logic       pend_rd;
  logic [7:0] sh;
  logic [7:0] rx;
  logic [2:0] cnt;
  logic       busy;
  logic       phase_done;
  logic       start;
  logic       wr_edge;
  logic       rd_edge;

  assign wr_edge = enviar_dato & ~prev_wr;
  assign rd_edge = recibir_dato & ~prev_rd;
  assign start = clken & (state == S_IDLE)
               & (pend_wr | pend_rd);
  assign oe = recibir_dato;
  assign spi_transfer_in_progress = busy;

`ifdef SPI_SLOW_MODE_EN
  logic [7:0] div;
  logic       slow_q;

  assign phase_done = ~slow_q | (div == SLOW_DIV);

  // Per-phase tick divider; slow is latched only at transfer start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= 8'd0;
      slow_q <= 1'b0;
    end else if (clken) begin
      if (start) begin
        slow_q <= slow;
        div    <= 8'd0;
      end else if (state != S_IDLE) begin
        div <= phase_done ? 8'd0 : div + 8'd1;
      end
    end
  end
`else
  logic unused_slow;

  assign unused_slow = slow;
  assign phase_done = 1'b1;
`endif

  // Request level history for rising-edge detection (runs regardless of clken)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_wr <= 1'b0;
      prev_rd <= 1'b0;
    end else begin
      prev_wr <= enviar_dato;
      prev_rd <= recibir_dato;
    end
  end

  // Pending flags: edges latch only while idle; a start consumes both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_wr <= 1'b0;
      pend_rd <= 1'b0;
    end else if (start) begin
      pend_wr <= 1'b0;
      pend_rd <= 1'b0;
    end else if (state == S_IDLE) begin
      pend_wr <= pend_wr | wr_edge;
      pend_rd <= pend_rd | rd_edge;
    end
  end

  // Shift engine: IDLE -> LOW -> HIGH -> ... -> IDLE, one bit per LOW/HIGH pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sclk  <= 1'b0;
      mosi  <= 1'b1;
      busy  <= 1'b0;
      sh    <= 8'd0;
      rx    <= 8'd0;
      cnt   <= 3'd0;
      dout  <= 8'hFF;
    end else if (clken) begin
      case (state)
        S_IDLE: begin
          if (pend_wr | pend_rd) begin
            busy  <= 1'b1;
            sh    <= pend_wr ? din : 8'hFF;
            mosi  <= pend_wr ? din[7] : 1'b1;
            cnt   <= 3'd0;
            sclk  <= 1'b0;
            state <= S_LOW;
          end
        end
        S_LOW: begin
          if (phase_done) begin
            sclk  <= 1'b1;
            rx    <= {rx[6:0], miso};
            state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (phase_done) begin
            sclk <= 1'b0;
            if (cnt == 3'd7) begin
              dout  <= rx;
              busy  <= 1'b0;
              mosi  <= 1'b1;
              state <= S_IDLE;
            end else begin
              sh    <= {sh[6:0], 1'b0};
              mosi  <= sh[6];
              cnt   <= cnt + 3'd1;
              state <= S_LOW;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine: randomized transfers against a byte-level SPI model.
// Slow-mode expectations apply when SPI_SLOW_MODE_EN is defined.
module tb_spi_byte_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clken = 1'b1;
  logic       enviar_dato = 1'b0;
  logic       recibir_dato = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe;
  logic       busy;
  logic       slow = 1'b0;
  logic       sclk;
  logic       mosi;
  logic       miso;

  int checks = 0;
  int errors = 0;

  logic [7:0] slave_byte = 8'h00;
  logic [7:0] cap = 8'h00;
  int         rise_total = 0;
  int         base = 0;
  logic [7:0] model_dout = 8'hFF;
  logic [2:0] ridx;

  spi_byte_engine #(.SLOW_DIV(8'd3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clken(clken),
    .enviar_dato(enviar_dato),
    .recibir_dato(recibir_dato),
    .din(din),
    .dout(dout),
    .oe(oe),
    .spi_transfer_in_progress(busy),
    .slow(slow),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso)
  );

  always #5 clk = ~clk;

  // Slave: presents the next MSB-first bit until each sclk rise
  assign ridx = 3'(rise_total - base);
  assign miso = slave_byte[3'd7 - ridx];

  always @(posedge sclk) begin
    cap = {cap[6:0], mosi};
    rise_total = rise_total + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp_v);
    end
  endtask

  function automatic int phase_ticks(input logic s);
`ifdef SPI_SLOW_MODE_EN
    return s ? 4 : 1;
`else
    return 1;
`endif
  endfunction

  // One CPU access; expectations come from the byte-level model
  task automatic xfer(input bit wr, input bit rd,
                      input logic [7:0] d,
                      input logic [7:0] s);
    logic [7:0] exp_tx;
    int w;
    int n;
    int h;
    h = phase_ticks(slow);
    exp_tx = wr ? d : 8'hFF;
    @(negedge clk);
    slave_byte = s;
    base = rise_total;
    din = d;
    enviar_dato = wr;
    recibir_dato = rd;
    #1;
    check("oe", oe, rd);
    check("dout_pre", dout, model_dout);
    w = 0;
    while (!busy && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!busy) begin
      check("start_timeout", 0, 1);
    end else begin
      n = 0;
      while (busy && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("busy_len", n, 16 * h);
      check("tx", cap, exp_tx);
      check("rises", rise_total - base, 8);
      check("dout", dout, s);
      model_dout = s;
    end
    enviar_dato = 1'b0;
    recibir_dato = 1'b0;
    repeat (3) @(negedge clk);
    check("no_follow", busy, 0);
  endtask

  initial begin
    int w;
    bit wr;
    bit rd;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 1);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 8'hFF);
    check("rst_oe", oe, 0);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(1'b1, 1'b0, 8'hA5, 8'h00);
    xfer(1'b1, 1'b0, 8'h11, 8'h3C);
    xfer(1'b0, 1'b1, 8'h00, 8'hC7);
    xfer(1'b1, 1'b1, 8'h5A, 8'h96);

    // Held strobe plus a re-edge while busy: one transfer only
    @(negedge clk);
    base = rise_total;
    slave_byte = 8'h81;
    din = 8'hE3;
    enviar_dato = 1'b1;
    repeat (5) @(negedge clk);
    enviar_dato = 1'b0;
    @(negedge clk);
    enviar_dato = 1'b1;
    repeat (100) @(negedge clk);
    check("hold_rises", rise_total - base, 8);
    check("hold_tx", cap, 8'hE3);
    check("hold_busy", busy, 0);
    check("hold_dout", dout, 8'h81);
    model_dout = 8'h81;
    enviar_dato = 1'b0;
    @(negedge clk);

    // clken low: request latched, engine frozen until tick returns
    clken = 1'b0;
    base = rise_total;
    slave_byte = 8'h42;
    din = 8'h24;
    enviar_dato = 1'b1;
    repeat (6) @(negedge clk);
    check("frozen_busy", busy, 0);
    check("frozen_rises", rise_total - base, 0);
    clken = 1'b1;
    repeat (40) @(negedge clk);
    check("clken_tx", cap, 8'h24);
    check("clken_dout", dout, 8'h42);
    model_dout = 8'h42;
    enviar_dato = 1'b0;
    @(negedge clk);

    // Randomized mix of writes, reads and collisions
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      slow = (i % 6 == 5);
      xfer(wr, rd, 8'($urandom), 8'($urandom));
      slow = 1'b0;
    end

    slow = 1'b1;
    xfer(1'b1, 1'b0, 8'hC3, 8'h5E);

    // Reset mid-transfer discards partial byte
    @(negedge clk);
    base = rise_total;
    slave_byte = 8'h0F;
    din = 8'hF0;
    enviar_dato = 1'b1;
    w = 0;
    while ((rise_total - base) < 4 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("mid_reached", rise_total - base, 4);
    rst_n = 1'b0;
    #1;
    check("mid_sclk", sclk, 0);
    check("mid_busy", busy, 0);
    check("mid_dout", dout, 8'hFF);
    check("mid_mosi", mosi, 1);
    model_dout = 8'hFF;
    enviar_dato = 1'b0;
    slow = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 1'b1, 8'h00, 8'h6D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
